// File: rtl/mbc_header_loader.sv
// mbc_header_loader: reads the cartridge header at boot, latches mapper config, holds the CPU off the bus until done.
// Define MBC_HDR_CHECKSUM_EN to read 0x134..0x14d and verify the header checksum.
module mbc_header_loader #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reload,
    input  logic [14:0] cpu_iadr,
    input  logic        cpu_rd,
    input  logic        cpu_ics_rom,
    output logic [14:0] bus_iadr,
    output logic        bus_rd,
    output logic        bus_ics_rom,
    input  logic [7:0]  bus_data,
    input  logic        bus_ack,
    output logic        cpu_hold,
    output logic [7:0]  cart_type,
    output logic [2:0]  rom_size,
    output logic [1:0]  ram_size,
    output logic        hdr_done,
    output logic        hdr_err
);
`ifdef MBC_HDR_CHECKSUM_EN
    localparam logic [14:0] FIRST = 15'h134;
    localparam logic [14:0] LAST  = 15'h14d;
`else
    localparam logic [14:0] FIRST = 15'h147;
    localparam logic [14:0] LAST  = 15'h149;
`endif
    localparam logic [TIMEOUT_W-1:0] TLAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {START, REQ, WAIT, NEXT, CHECK, DONE, ERROR} state_t;

    state_t               state, next;
    logic [14:0]          adr;
    logic [TIMEOUT_W-1:0] tcnt;
    logic [7:0]           b147, b148, b149;
    logic [2:0]           rom_dec;
    logic [1:0]           ram_dec;
    logic                 err_dec, loader, owned;
`ifdef MBC_HDR_CHECKSUM_EN
    logic [7:0]           csum, b14d;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= START;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            START:   next = REQ;
            REQ:     next = WAIT;
            WAIT:    next = bus_ack ? NEXT : (tcnt == TLAST ? ERROR : WAIT);
            NEXT:    next = adr == LAST ? CHECK : REQ;
            CHECK:   next = DONE;
            default: next = reload ? START : state;
        endcase
    end

    // The mux select is the registered state, so the bus never mixes loader and CPU signals.
    always_comb begin
        loader      = state == REQ || state == WAIT;
        owned       = state == DONE || state == ERROR;
        cpu_hold    = !owned;
        bus_iadr    = owned ? cpu_iadr : (loader ? adr : '0);
        bus_rd      = owned ? cpu_rd : loader;
        bus_ics_rom = owned ? cpu_ics_rom : loader;
    end

    always_comb begin
        rom_dec = b148 > 8'd6 ? 3'd6 : b148[2:0];
        ram_dec = b149 > 8'd3 ? 2'd3 : (b149 < 8'd2 ? 2'd0 : b149[1:0]);
`ifdef MBC_HDR_CHECKSUM_EN
        err_dec = b148 > 8'd6 || b149 > 8'd3 || csum != b14d;
`else
        err_dec = b148 > 8'd6 || b149 > 8'd3;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            adr       <= FIRST;
            tcnt      <= '0;
            b147      <= '0;
            b148      <= '0;
            b149      <= '0;
            cart_type <= '0;
            rom_size  <= '0;
            ram_size  <= '0;
            hdr_done  <= 1'b0;
            hdr_err   <= 1'b0;
`ifdef MBC_HDR_CHECKSUM_EN
            csum      <= '0;
            b14d      <= '0;
`endif
        end else begin
            case (state)
                START: begin
                    adr  <= FIRST;
                    tcnt <= '0;
`ifdef MBC_HDR_CHECKSUM_EN
                    csum <= '0;
`endif
                end
                REQ: tcnt <= '0;
                WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    if (bus_ack) begin
                        if (adr == 15'h147) b147 <= bus_data;
                        if (adr == 15'h148) b148 <= bus_data;
                        if (adr == 15'h149) b149 <= bus_data;
`ifdef MBC_HDR_CHECKSUM_EN
                        if (adr == LAST)
                            b14d <= bus_data;
                        else
                            csum <= csum - bus_data - 8'd1;
`endif
                    end else if (tcnt == TLAST) begin
                        cart_type <= '0;
                        rom_size  <= '0;
                        ram_size  <= '0;
                        hdr_err   <= 1'b1;
                        hdr_done  <= 1'b1;
                    end
                end
                NEXT: adr <= adr + 15'd1;
                CHECK: begin
                    cart_type <= b147;
                    rom_size  <= rom_dec;
                    ram_size  <= ram_dec;
                    hdr_err   <= err_dec;
                    hdr_done  <= 1'b1;
                end
                default: begin
                    if (reload) begin
                        hdr_done <= 1'b0;
                        hdr_err  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
